// File: rtl/wa_arb_3ch_if.sv
// Write-address bundle between three request channels, the 3-to-1 arbiter
// and its single downstream write-address port.
interface wa_arb_3ch_if #(
    parameter int ADDR_W = 32
);
    logic              wavalid0;
    logic              wavalid1;
    logic              wavalid2;
    logic [ADDR_W-1:0] waaddr0;
    logic [ADDR_W-1:0] waaddr1;
    logic [ADDR_W-1:0] waaddr2;
    logic [7:0]        walen0;
    logic [7:0]        walen1;
    logic [7:0]        walen2;
    logic              waready0;
    logic              waready1;
    logic              waready2;
    logic              wasuc0;
    logic              wasuc1;
    logic              wasuc2;
    logic              m_awvalid;
    logic              m_awready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic [1:0]        m_awsrc;

    // Arbiter side: consumes channel requests, drives the downstream port.
    modport slave (
        input  wavalid0, wavalid1, wavalid2,
        input  waaddr0, waaddr1, waaddr2,
        input  walen0, walen1, walen2,
        input  m_awready,
        output waready0, waready1, waready2,
        output wasuc0, wasuc1, wasuc2,
        output m_awvalid, m_awaddr, m_awlen, m_awsrc
    );

    // Environment side: drives channel requests and downstream ready.
    modport master (
        output wavalid0, wavalid1, wavalid2,
        output waaddr0, waaddr1, waaddr2,
        output walen0, walen1, walen2,
        output m_awready,
        input  waready0, waready1, waready2,
        input  wasuc0, wasuc1, wasuc2,
        input  m_awvalid, m_awaddr, m_awlen, m_awsrc
    );
endinterface

// File: rtl/wa_arb_3ch.sv
// Three-to-one write-address arbiter with fixed-priority, round-robin and
// weighted round-robin policies, feeding a one-entry output register.
module wa_arb_3ch #(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arb_en,
    input  logic [1:0]  arb_mode,
    input  logic [15:0] weight_setting0,
    input  logic [15:0] weight_setting1,
    input  logic [15:0] weight_setting2,
    wa_arb_3ch_if.slave bus
);

    localparam logic [1:0]  MODE_RR  = 2'd1;
    localparam logic [1:0]  MODE_WRR = 2'd2;
    localparam logic [16:0] CNT_MAX  = 17'h1FFFF;

    logic [2:0]        valid;
    logic [2:0]        req;
    logic [2:0]        grant;
    logic [2:0]        ready;
    logic [2:0]        suc;
    logic              any_suc;
    logic [1:0]        suc_idx;
    logic              can_accept;

    logic              owner_req;
    logic [15:0]       owner_w;
    logic              owner_keep;

    logic [1:0]        last_q, last_d;
    logic [1:0]        owner_q, owner_d;
    logic [16:0]       run_cnt_q, run_cnt_d;

    logic              m_awvalid_q, m_awvalid_d;
    logic [ADDR_W-1:0] m_awaddr_q, m_awaddr_d;
    logic [7:0]        m_awlen_q, m_awlen_d;
    logic [1:0]        m_awsrc_q, m_awsrc_d;

    // Lowest index wins.
    function automatic logic [2:0] fixed_pick(input logic [2:0] r);
        logic [2:0] g;
        g = 3'b000;
        if (r[0])      g = 3'b001;
        else if (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
        return g;
    endfunction

    // Search starts one past prev, so prev itself is considered last.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] prev);
        logic [2:0] g;
        g = 3'b000;
        case (prev)
            2'd0: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            2'd1: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: g = fixed_pick(r);
        endcase
        return g;
    endfunction

    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        logic [2:0] g;
        g = 3'b000;
        case (idx)
            2'd0:    g = 3'b001;
            2'd1:    g = 3'b010;
            2'd2:    g = 3'b100;
            default: g = 3'b000;
        endcase
        return g;
    endfunction

    assign valid      = {bus.wavalid2, bus.wavalid1, bus.wavalid0};
    // With arbitration disabled only channel 0 may ever be granted.
    assign req        = arb_en ? valid : {2'b00, valid[0]};
    assign can_accept = ~m_awvalid_q | bus.m_awready;

    // Weighted RR: does the current owner still have credit and a request?
    always_comb begin
        owner_req = 1'b0;
        owner_w   = weight_setting0;
        case (owner_q)
            2'd0: begin owner_req = req[0]; owner_w = weight_setting0; end
            2'd1: begin owner_req = req[1]; owner_w = weight_setting1; end
            2'd2: begin owner_req = req[2]; owner_w = weight_setting2; end
            default: begin owner_req = 1'b0; owner_w = weight_setting0; end
        endcase
        owner_keep = owner_req & (run_cnt_q <= {1'b0, owner_w});
    end

    // Grant selection per policy; reserved mode falls back to fixed priority.
    always_comb begin
        grant = fixed_pick(req);
        case (arb_mode)
            MODE_RR:  grant = rr_pick(req, last_q);
            MODE_WRR: grant = owner_keep ? idx_onehot(owner_q) : rr_pick(req, owner_q);
            default:  grant = fixed_pick(req);
        endcase
    end

    assign ready   = grant & {3{can_accept}};
    assign suc     = valid & ready;
    assign any_suc = |suc;
    assign suc_idx = suc[1] ? 2'd1 : (suc[2] ? 2'd2 : 2'd0);

    // Next state of arbitration history and the output buffer.
    always_comb begin
        last_d      = last_q;
        owner_d     = owner_q;
        run_cnt_d   = run_cnt_q;
        m_awvalid_d = m_awvalid_q;
        m_awaddr_d  = m_awaddr_q;
        m_awlen_d   = m_awlen_q;
        m_awsrc_d   = m_awsrc_q;

        if (any_suc) begin
            // History tracks every handshake so a mode switch needs no flush.
            last_d = suc_idx;
            if (suc_idx == owner_q) begin
                run_cnt_d = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + 17'd1;
            end else begin
                owner_d   = suc_idx;
                run_cnt_d = 17'd1;
            end

            m_awvalid_d = 1'b1;
            m_awsrc_d   = suc_idx;
            case (suc_idx)
                2'd1:    begin m_awaddr_d = bus.waaddr1; m_awlen_d = bus.walen1; end
                2'd2:    begin m_awaddr_d = bus.waaddr2; m_awlen_d = bus.walen2; end
                default: begin m_awaddr_d = bus.waaddr0; m_awlen_d = bus.walen0; end
            endcase
        end else if (bus.m_awready) begin
            m_awvalid_d = 1'b0;
        end
    end

    // State registers; reset drops any buffered entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 2'd2;
            owner_q     <= 2'd0;
            run_cnt_q   <= 17'd0;
            m_awvalid_q <= 1'b0;
            m_awaddr_q  <= '0;
            m_awlen_q   <= 8'd0;
            m_awsrc_q   <= 2'd0;
        end else begin
            last_q      <= last_d;
            owner_q     <= owner_d;
            run_cnt_q   <= run_cnt_d;
            m_awvalid_q <= m_awvalid_d;
            m_awaddr_q  <= m_awaddr_d;
            m_awlen_q   <= m_awlen_d;
            m_awsrc_q   <= m_awsrc_d;
        end
    end

    assign bus.waready0  = ready[0];
    assign bus.waready1  = ready[1];
    assign bus.waready2  = ready[2];
    assign bus.wasuc0    = suc[0];
    assign bus.wasuc1    = suc[1];
    assign bus.wasuc2    = suc[2];
    assign bus.m_awvalid = m_awvalid_q;
    assign bus.m_awaddr  = m_awaddr_q;
    assign bus.m_awlen   = m_awlen_q;
    assign bus.m_awsrc   = m_awsrc_q;

endmodule

// File: doc/wa_arb_3ch.md
# wa_arb_3ch

Three-to-one write-address arbiter: accepts AXI-style write-address requests from channels 0/1/2, selects one per cycle using the configured policy (fixed priority, round-robin or weighted round-robin) and forwards it through a one-entry output register to the single downstream write-address port. It emits the per-channel `wasuc0..2` handshake strobes that the write-address assertion checker in the 3-channel environment monitors.

## Interface
- `ADDR_W`, 32, address width of every channel and of the output
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `arb_en`  in  1  1 = arbitrate all channels; 0 = only channel 0 is served
- `arb_mode`  in  2  0 fixed priority, 1 round-robin, 2 weighted RR, 3 reserved (behaves as 0)
- `weight_setting0..2`  in  16 each  weighted-RR weight per channel
- `wavalid0..2`  in  1 each  channel request valid
- `waaddr0..2`  in  ADDR_W each  channel address
- `walen0..2`  in  8 each  channel burst length
- `waready0..2`  out  1 each  channel ready
- `wasuc0..2`  out  1 each  handshake strobe, `wavalidN & wareadyN`
- `m_awvalid`  out  1  output request valid
- `m_awready`  in  1  downstream ready
- `m_awaddr`  out  ADDR_W  forwarded address
- `m_awlen`  out  8  forwarded length
- `m_awsrc`  out  2  index of the source channel

## Operation
- Output buffer: one entry (`m_awvalid`, payload). `can_accept = ~m_awvalid | m_awready`.
- Each cycle the arbiter computes a combinational one-hot `grant` from the eligible valids. `wareadyN = grant[N] & can_accept`. At most one `wasuc` is high per cycle.
- Eligibility: `arb_en=0` makes only channel 0 eligible, so `waready1/2` stay 0. `arb_en=1` makes all channels eligible.
- Mode 0/3 (fixed priority): 0 > 1 > 2.
- Mode 1 (round-robin):
  - `last` register records the most recently granted channel; search order starts at `last+1` mod 3.
  - `last` updates only on a `wasuc`.
- Mode 2 (weighted RR):
  - State: `owner` (2 bits) and `run_cnt` (17 bits, saturating at 0x1FFFF).
  - If `owner` is valid and `run_cnt <= weight_settingOWNER`, the owner keeps the grant.
  - Otherwise, round-robin search from `owner+1`. The owner itself is chosen last, so it continues only when no other channel is valid.
  - On a `wasuc` from the owner: `run_cnt` increments.
  - On a `wasuc` from another channel: `owner` changes and `run_cnt` is set to 1.
  - Result: a channel gets at most `weight+1` consecutive grants while another channel waits.
- `last`, `owner` and `run_cnt` update on every `wasuc` regardless of mode, so a mode switch takes effect on the next decision without a flush.
- On a `wasuc`: the buffer loads `{waaddrN, walenN, N}` and `m_awvalid` is set.
- When `m_awvalid & m_awready` with no new `wasuc`: `m_awvalid` clears.
- Payload registers update only on a load; they hold their value while `m_awvalid & ~m_awready`.
- `arb_en` deasserting while an entry is buffered: the entry still drains normally.

## Timing
- Reset values:
  - `m_awvalid` 0, `m_awaddr` 0, `m_awlen` 0, `m_awsrc` 0.
  - `waready0..2` 0 (no valids present); `wasuc0..2` 0.
  - `last` 2 (channel 0 first), `owner` 0, `run_cnt` 0.
- `waready` and `wasuc` are combinational from the valids, the mode/config inputs, `m_awvalid` and `m_awready`. Nothing depends combinationally on the payload.
- Latency: a request accepted in cycle T appears on `m_aw*` with `m_awvalid=1` in cycle T+1.
- Throughput: one transfer per cycle when `m_awready` is held high. The buffer drains and reloads in the same cycle.
- Backpressure: `m_awready=0` with a full buffer forces all `waready` to 0 and holds the buffer stable.
- Simultaneous valids are resolved by the active mode in the same cycle. Config inputs are sampled every cycle, with no pipelining.
- `run_cnt` saturates and never wraps. A weight of 0xFFFF therefore allows 65536 consecutive grants.
- Asynchronous reset mid-transfer drops the buffered entry immediately.

## Test plan
- Fixed priority (`arb_en=1`, mode 0, all three valids held, `m_awready=1`) -> `wasuc0` every cycle; `wasuc1`/`wasuc2` never; `m_awsrc=0` from cycle 2.
- Arbiter disabled (`arb_en=0`, all valids high) -> only channel 0 handshakes. Then drop `wavalid0`: `waready1`/`waready2` stay 0 and `m_awvalid` falls one cycle later.
- Round-robin (mode 1, all valids high for 6 accepts, `m_awready=1`) -> grant sequence 0,1,2,0,1,2 and `m_awsrc` sequence 0,1,2,0,1,2, each one cycle behind its grant.
- Weighted RR (mode 2, weights 2/0/1, all valids high, `m_awready=1`) -> grant sequence 0,0,0,1,2,2,0,0,0,1,… ; no channel ever exceeds `weight+1` consecutive grants.
- Backpressure (mode 1, `m_awready=0` for 5 cycles after the first accept) -> exactly one `wasuc`; the buffer payload is stable for 5 cycles. When `m_awready` rises, the next accept goes to channel 1 in the same cycle as the drain.
- Mutual exclusion and reset -> random valids, modes and weights with assertion `!(wasucI & wasucJ)`. Asserting `rst_n` low with a full buffer drives `m_awvalid=0` before the next edge, and the first grant after reset goes to channel 0.
